// File: rtl/pix_window3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one registered window per accepted interior pixel of a raster stream.
module pix_window3x3 #(
  parameter int IMG_W = 640,
  parameter int CNT_W = 11
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic [23:0]    i_vid_data,
  input  logic           i_vid_valid,
  input  logic           i_vid_sof,
  input  logic           i_vid_eol,
  output logic [215:0]   o_win,
  output logic           o_win_valid,
  output logic           o_win_sof,
  output logic           o_win_eol,
  output logic           o_line_err
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);

  logic [CNT_W-1:0] r_col;
  logic [1:0]       r_row;
  logic             r_row2_done;  // a row at count 2 has already ended in this frame
  logic             r_armed;      // a sof has been seen since reset
  logic [215:0]     r_win;
  logic [23:0]      r_lb0 [IMG_W];
  logic [23:0]      r_lb1 [IMG_W];

  logic [CNT_W-1:0] w_col;
  logic [CNT_W-1:0] w_col_nx;
  logic [AW-1:0]    w_addr;
  logic [1:0]       w_row;
  logic [1:0]       w_row_nx;
  logic             w_row2_done;
  logic             w_row2_done_nx;
  logic             w_armed;
  logic             w_at_last;
  logic             w_line_end;
  logic             w_line_err;
  logic             w_emit;
  logic             w_first;
  logic [23:0]      w_lb0_rd;
  logic [23:0]      w_lb1_rd;
  logic [215:0]     w_win_next;

  always_comb begin
    w_col          = i_vid_sof ? '0 : r_col;
    w_row          = i_vid_sof ? 2'd0 : r_row;
    w_row2_done    = i_vid_sof ? 1'b0 : r_row2_done;
    w_armed        = r_armed | i_vid_sof;
    w_addr         = w_col[AW-1:0];
    w_lb0_rd       = r_lb0[w_addr];
    w_lb1_rd       = r_lb1[w_addr];
    w_at_last      = (w_col == LAST_COL);
    w_line_end     = i_vid_eol | w_at_last;
    w_line_err     = i_vid_eol ^ w_at_last;
    w_emit         = w_armed && (w_row == 2'd2) && (w_col >= CNT_W'(2));
    w_first        = w_emit && !w_row2_done && (w_col == CNT_W'(2));
    w_col_nx       = w_col + CNT_W'(1);
    w_row_nx       = w_row;
    w_row2_done_nx = w_row2_done;
    if (w_line_end) begin
      w_col_nx       = '0;
      w_row_nx       = (w_row == 2'd2) ? 2'd2 : 2'(w_row + 2'd1);
      w_row2_done_nx = w_row2_done | (w_row == 2'd2);
    end else begin
      w_col_nx       = w_col + CNT_W'(1);
    end
    // Shift every row left by one slot; the new right column is {LB1, LB0, input}.
    w_win_next = r_win;
    for (int r = 0; r < 3; r++) begin
      w_win_next[24*(3*r)   +: 24] = r_win[24*(3*r+1) +: 24];
      w_win_next[24*(3*r+1) +: 24] = r_win[24*(3*r+2) +: 24];
    end
    w_win_next[24*2 +: 24] = w_lb1_rd;
    w_win_next[24*5 +: 24] = w_lb0_rd;
    w_win_next[24*8 +: 24] = i_vid_data;
  end

  // Line buffer RAM: read-before-write, contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_vid_valid) begin
      r_lb1[w_addr] <= w_lb0_rd;
      r_lb0[w_addr] <= i_vid_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_col       <= '0;
      r_row       <= 2'd0;
      r_row2_done <= 1'b0;
      r_armed     <= 1'b0;
      r_win       <= '0;
      o_win       <= '0;
      o_win_valid <= 1'b0;
      o_win_sof   <= 1'b0;
      o_win_eol   <= 1'b0;
      o_line_err  <= 1'b0;
    end else if (i_vid_valid) begin
      r_col       <= w_col_nx;
      r_row       <= w_row_nx;
      r_row2_done <= w_row2_done_nx;
      r_armed     <= w_armed;
      r_win       <= w_win_next;
      o_win_valid <= w_emit;
      o_win_sof   <= w_first;
      o_win_eol   <= w_emit & w_line_end;
      o_line_err  <= w_line_err;
      if (w_emit) begin
        o_win <= w_win_next;
      end
    end else begin
      o_win_valid <= 1'b0;
      o_win_sof   <= 1'b0;
      o_win_eol   <= 1'b0;
      o_line_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pix_window3x3.sv
// Bench for pix_window3x3 at IMG_W=4: constant vector table, directed corner
// sequences and random frames checked against an image-array reference model.
module tb_pix_window3x3;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [23:0]  i_vid_data;
  logic         i_vid_valid;
  logic         i_vid_sof;
  logic         i_vid_eol;
  logic [215:0] o_win;
  logic         o_win_valid;
  logic         o_win_sof;
  logic         o_win_eol;
  logic         o_line_err;

  pix_window3x3 #(.IMG_W(W), .CNT_W(3)) dut (
    .clk(clk), .n_rst(n_rst), .i_vid_data(i_vid_data), .i_vid_valid(i_vid_valid),
    .i_vid_sof(i_vid_sof), .i_vid_eol(i_vid_eol), .o_win(o_win), .o_win_valid(o_win_valid),
    .o_win_sof(o_win_sof), .o_win_eol(o_win_eol), .o_line_err(o_line_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_win  = 0;

  // Reference model: absolute row/column position and a picture of the frame so far.
  int           m_row, m_col;
  bit           m_armed, m_clean;
  logic [23:0]  img [64][W];
  logic [215:0] m_owin;
  bit           m_owin_known;
  logic         e_valid, e_sof, e_eol, e_err;
  logic [215:0] e_win;
  bit           e_win_ok;

  typedef struct {
    logic s, e; logic [23:0] d;
    logic ev, esof, eeol; logic [23:0] k0, k4, k8;
  } vec_t;
  vec_t tv [12];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk_px(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%06h, want 0x%06h", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input logic [215:0] act, input logic [215:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_armed = 0; m_clean = 0;
    m_owin = '0; m_owin_known = 1;
  endtask

  task automatic model_accept(input logic s, input logic e, input logic [23:0] d);
    bit at_last, line_end;
    if (s) begin
      m_row = 0; m_col = 0; m_armed = 1; m_clean = 1;
    end
    if (m_row < 64) img[m_row][m_col] = d;
    at_last  = (m_col == W - 1);
    line_end = e || at_last;
    e_err    = (e != at_last);
    e_valid  = m_armed && m_row >= 2 && m_col >= 2;
    e_sof    = e_valid && m_row == 2 && m_col == 2;
    e_eol    = e_valid && line_end;
    e_win_ok = m_clean && m_row < 64;
    e_win    = '0;
    if (e_valid && e_win_ok)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e_win[24*(3*r+c) +: 24] = img[m_row-2+r][m_col-2+c];
    if (line_end) begin
      m_col = 0; m_row++;
      if (e_err) m_clean = 0;
    end else begin
      m_col++;
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic [23:0] d);
    @(negedge clk);
    i_vid_valid = v; i_vid_sof = s; i_vid_eol = e; i_vid_data = d;
    e_valid = 0; e_sof = 0; e_eol = 0; e_err = 0;
    if (v) model_accept(s, e, d);
    @(posedge clk);
    #1;
    chk_bit("win_valid", o_win_valid, e_valid);
    chk_bit("win_sof", o_win_sof, e_sof);
    chk_bit("win_eol", o_win_eol, e_eol);
    chk_bit("line_err", o_line_err, e_err);
    if (o_win_valid) n_win++;
    if (e_valid) begin
      if (e_win_ok) begin
        chk_win("win_data", o_win, e_win);
        m_owin = e_win; m_owin_known = 1;
      end else begin
        m_owin_known = 0;
      end
    end else if (m_owin_known) begin
      chk_win("win_hold", o_win, m_owin);
    end
  endtask

  task automatic idle_rand();
    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
  endtask

  task automatic send_frame(input int h, input bit gaps, input bit rnd);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps) idle_rand();
        step(1'b1, 1'(r == 0 && c == 0), 1'(c == W - 1),
             rnd ? 24'($urandom) : 24'(r * 16 + c));
      end
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[1]  = '{1'b0, 1'b0, 24'h000001, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[2]  = '{1'b0, 1'b0, 24'h000002, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[3]  = '{1'b0, 1'b1, 24'h000003, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[4]  = '{1'b0, 1'b0, 24'h000010, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[5]  = '{1'b0, 1'b0, 24'h000011, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[6]  = '{1'b0, 1'b0, 24'h000012, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[7]  = '{1'b0, 1'b1, 24'h000013, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[8]  = '{1'b0, 1'b0, 24'h000020, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[9]  = '{1'b0, 1'b0, 24'h000021, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
    tv[10] = '{1'b0, 1'b0, 24'h000022, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000011, 24'h000022};
    tv[11] = '{1'b0, 1'b1, 24'h000023, 1'b1, 1'b0, 1'b1, 24'h000001, 24'h000012, 24'h000023};

    n_rst = 1'b0; i_vid_valid = 1'b0; i_vid_sof = 1'b0; i_vid_eol = 1'b0; i_vid_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_win("rst_win", o_win, '0);
    chk_bit("rst_valid", o_win_valid, 1'b0);
    chk_bit("rst_sof", o_win_sof, 1'b0);
    chk_bit("rst_eol", o_win_eol, 1'b0);
    chk_bit("rst_err", o_line_err, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    // 4x3 frame, continuous valid, against the constant table.
    n_win = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tv[i].s, tv[i].e, tv[i].d);
      chk_bit("t1_valid", o_win_valid, tv[i].ev);
      if (tv[i].ev) begin
        chk_bit("t1_sof", o_win_sof, tv[i].esof);
        chk_bit("t1_eol", o_win_eol, tv[i].eeol);
        chk_px("t1_k0", o_win[0 +: 24], tv[i].k0);
        chk_px("t1_k4", o_win[96 +: 24], tv[i].k4);
        chk_px("t1_k8", o_win[192 +: 24], tv[i].k8);
      end
    end
    chk_int("t1_count", n_win, 2);

    // Same frame with valid low every other cycle.
    n_win = 0;
    send_frame(3, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    chk_int("t2_count", n_win, 2);
    chk_px("t2_k4_held", o_win[96 +: 24], 24'h000012);

    // 4x4 frame: four windows, row-3 top-left is pixel (1,0).
    n_win = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, 1'(r == 0 && c == 0), 1'(c == W - 1), 24'(r * 16 + c));
        if (r == 3 && c == 2) chk_px("t3_k0", o_win[0 +: 24], 24'h000010);
      end
    chk_int("t3_count", n_win, 4);

    // Early eol on row 1 col 2, then a row-3 line that runs full without eol.
    n_win = 0;
    for (int c = 0; c < W; c++) step(1'b1, 1'(c == 0), 1'(c == W - 1), 24'(c));
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'(c == 2), 24'(16 + c));
    chk_bit("t4_err_early", o_line_err, 1'b1);
    for (int c = 0; c < W; c++) step(1'b1, 1'b0, 1'(c == W - 1), 24'(32 + c));
    chk_int("t4_row2_windows", n_win, 2);
    for (int c = 0; c < W; c++) step(1'b1, 1'b0, 1'b0, 24'(48 + c));
    chk_bit("t4_err_missing", o_line_err, 1'b1);
    step(1'b0, 1'b0, 1'b0, 24'h0);

    // sof re-asserted in the middle of row 2.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) step(1'b1, 1'(r == 0 && c == 0), 1'(c == W - 1), 24'(r * 16 + c + 5));
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, 24'(32 + c + 5));
    n_win = 0;
    send_frame(3, 1'b0, 1'b1);
    chk_int("t5_count", n_win, 2);

    // Asynchronous reset in the middle of row 2.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) step(1'b1, 1'(r == 0 && c == 0), 1'(c == W - 1), 24'(r * 16 + c + 1));
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, 24'(32 + c + 1));
    chk_bit("t6_pre_valid", o_win_valid, 1'b1);
    i_vid_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    chk_win("t6_rst_win", o_win, '0);
    chk_bit("t6_rst_valid", o_win_valid, 1'b0);
    chk_bit("t6_rst_sof", o_win_sof, 1'b0);
    chk_bit("t6_rst_eol", o_win_eol, 1'b0);
    chk_bit("t6_rst_err", o_line_err, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    n_win = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) step(1'b1, 1'b0, 1'(c == W - 1), 24'(r * 16 + c + 9));
    chk_int("t6_no_window_without_sof", n_win, 0);
    send_frame(3, 1'b0, 1'b1);
    chk_int("t6_after_sof", n_win, 2);

    // Random frames with random gaps carrying ignored framing bits.
    for (int f = 0; f < 8; f++) begin
      int h;
      h = $urandom_range(3, 6);
      n_win = 0;
      for (int r = 0; r < h; r++)
        for (int c = 0; c < W; c++) begin
          if ($urandom_range(0, 2) == 0) idle_rand();
          step(1'b1, 1'(r == 0 && c == 0), 1'(c == W - 1), 24'($urandom));
        end
      chk_int("rnd_count", n_win, (h - 2) * (W - 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pix_window3x3.md
# pix_window3x3

Streaming 3x3 neighbourhood generator feeding the multi-pixel filter stage (blur, vertical/horizontal/combined Sobel). Accepts a raster pixel stream with valid/start-of-frame/end-of-line framing, keeps two line buffers plus a 3x3 shift window, and presents all nine 24-bit pixels in parallel with one registered window per accepted interior pixel. Pixel words are opaque to this block; the downstream filter unpacks them as {red, blu, gre}.

## Interface
- IMG_W, 640, active pixels per line; line buffer depth.
- CNT_W, 11, width of column counter; must satisfy 2^CNT_W >= IMG_W.
- clk  in  1  pixel clock, all logic on rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- i_vid_data  in  24  input pixel.
- i_vid_valid  in  1  pixel accepted this cycle when high; gaps allowed.
- i_vid_sof  in  1  qualified by valid; marks pixel (row 0, col 0).
- i_vid_eol  in  1  qualified by valid; marks last pixel of a line.
- o_win  out  216  window; slot k = o_win[24*k +: 24], k = 3*r + c, r,c in 0..2; k=0 top-left (oldest row, oldest column), k=8 = current input pixel; k=4 = centre.
- o_win_valid  out  1  one-cycle pulse per emitted window.
- o_win_sof  out  1  with o_win_valid, first window of frame.
- o_win_eol  out  1  with o_win_valid, last window of line.
- o_line_err  out  1  one-cycle pulse on line-length mismatch.

## Operation
- Counters: col (0..IMG_W-1), row (saturates at 2). Accepted pixel with sof forces col=0,row=0 for that pixel regardless of prior state (mid-frame sof restarts frame; line buffer contents are not cleared, only ignored via row count).
- Line advance: after accepted pixel with eol, or at col=IMG_W-1, col->0 and row increments (sat 2). Whichever comes first ends the line.
- o_line_err pulses when eol arrives with col != IMG_W-1, or when col=IMG_W-1 without eol. Line still ends.
- Line buffers LB0 (row-1), LB1 (row-2), IMG_W x 24 each, addressed by col, read-before-write: on accepted pixel, LB1[col] <= LB0[col], LB0[col] <= i_vid_data; old values form the new right column {LB1[col], LB0[col], i_vid_data}.
- Window shift: on accepted pixel, columns shift left by one; new right column inserted. No shift when valid low; window holds.
- Column shift register is not reset at line start; windows for col<2 are suppressed, so stale data never escapes.
- Emit rule: o_win_valid for accepted pixel at (row>=2, col>=2) as counted before advance. Window centre is input pixel (row-1, col-1). Frame of W x H yields (H-2)*(W-2) windows; no border padding.
- o_win_sof when emitted pixel has row count reaching 2 for first time in frame and col=2. o_win_eol when emitted pixel ends line (eol or col=IMG_W-1).
- Arithmetic: none on pixel data; counters wrap/saturate as stated, no overflow elsewhere.

## Timing
- Latency: 1 cycle from accepted pixel to o_win/o_win_valid/flags (registered).
- Throughput: one pixel per cycle sustained; no backpressure, downstream must accept every pulse.
- o_win holds last window between pulses; o_win_valid/sof/eol/line_err are single-cycle.
- Reset (n_rst low, async): o_win=0, o_win_valid=0, o_win_sof=0, o_win_eol=0, o_line_err=0, col=0, row=0, window regs=0. Line buffer RAM not reset. Assertion mid-frame aborts; first windows after release require sof plus two full lines.
- Inputs with i_vid_valid low are ignored entirely, including sof/eol.

## Test plan
- IMG_W=4, frame 4x3, pixel=row*16+col, continuous valid -> exactly 2 windows; first has o_win_sof=1, k4=0x000011, k0=0x000000, k8=0x000022; second has o_win_eol=1, k4=0x000012.
- Same frame with valid low every other cycle -> identical window contents/count; o_win stable between pulses.
- IMG_W=4, frame 4x4 -> 4 windows, o_win_eol on 2nd and 4th, o_win_sof only on 1st; row-3 window k0=0x000010.
- eol on col 2 of row 1 -> o_line_err pulse 1 cycle later; next pixel counted as col 0 of row 2.
- sof re-asserted mid row 2 -> no window until new row 2 col 2; next window has o_win_sof=1.
- n_rst low for 1 cycle mid-frame -> all outputs 0 immediately; no window until sof + two lines.
